dw01_sub_seq: RTL and testbench
===============================

# dw01_sub_seq

Multi-cycle unsigned subtractor with borrow-in and borrow-out. It computes A − B − BI one `chunk`-bit slice per cycle, from the least-significant slice upward. It is the subtract-direction counterpart of the library's combinational adder, for use in datapaths that trade latency for a short borrow chain per cycle. The block uses a start/busy/done handshake, and its result stays registered until the next operation completes.

## Interface
Parameters:
- `width`, 32: operand and result width in bits. Must be ≥ 1 and an exact multiple of `chunk`.
- `chunk`, 8: slice width processed per cycle. Derived value N = `width`/`chunk` is the number of processing cycles.

Ports:
- `clk`  input  1  single clock; all registers update on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request a new operation. Sampled only when `busy` = 0.
- `A`  input  `width`  minuend. Sampled on the same edge as an accepted `start`.
- `B`  input  `width`  subtrahend. Sampled with `start`.
- `BI`  input  1  borrow-in. Sampled with `start`.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse: `DIFF`/`BO` have just been updated.
- `DIFF`  output  `width`  registered result, (A − B − BI) mod 2^`width`.
- `BO`  output  1  registered borrow-out; 1 iff A < B + BI (unsigned).

## Operation
- States:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1, slice counter 0..N−1.
- IDLE → RUN on a rising edge where `start` = 1.
  - On that edge, A, B and BI are latched into internal operand registers.
  - The slice counter is cleared.
  - The internal borrow is loaded with BI.
- RUN, each edge:
  - Slice i = counter: partial difference = A[i] − B[i] − borrow, computed at `chunk`+1 bits.
  - The low `chunk` bits are written into slice i of an internal accumulator.
  - The new borrow is the MSB of that `chunk`+1-bit result.
  - The counter increments.
- RUN → IDLE on the edge that processes slice N−1. On that same edge:
  - `DIFF` is loaded with the full accumulator, including the final slice.
  - `BO` is loaded with the final borrow.
  - `done` is set to 1.
- `DIFF`/`BO` never show partial results; they change only on a completing edge.
- `done` is cleared on the next edge unless another operation completes on that edge.
- `start` while `busy` = 1 is ignored. Operands and the in-flight result are unaffected.
- Inputs A, B and BI may change freely after the accepting edge.
- Arithmetic is unsigned, modulo 2^`width`. No signed overflow flag is provided.
- N = 1 (`chunk` = `width`) is legal and degenerates to single-cycle RUN.

## Timing
- Reset (`rst_n` = 0, asynchronous): state IDLE, counter 0, `busy` = 0, `done` = 0, `DIFF` = 0, `BO` = 0, internal borrow/accumulator 0.
- Reset asserted mid-RUN abandons the operation. No `done` follows after release.
- `start` accepted at edge t0:
  - `busy` = 1 from t0 until edge t0+N.
  - `done` = 1 and `DIFF`/`BO` valid for the cycle following edge t0+N.
  - Latency is N cycles (4 at the defaults).
- Back-to-back operation: `start` high during the `done` cycle is accepted, because `busy` is already 0.
  - The next `done` arrives N cycles later, giving a throughput of one result per N cycles.
- `DIFF`/`BO` hold their value indefinitely in IDLE.

## Test plan
Defaults: `width` = 32, `chunk` = 8, N = 4.
- A=0x00000005, B=0x00000003, BI=0, start at t0 → `done` after edge t0+4; DIFF=0x00000002, BO=0; `busy` high for exactly 4 cycles.
- Borrow ripple through all slices: A=0x00000000, B=0x00000001, BI=0 → DIFF=0xFFFFFFFF, BO=1. Also A=0x80000000, B=0x00000001 → DIFF=0x7FFFFFFF, BO=0.
- Borrow-in with equal operands: A=B=0x12345678, BI=1 → DIFF=0xFFFFFFFF, BO=1. The same operands with BI=0 → DIFF=0, BO=0.
- Start while busy: run A=0x100, B=0x1; pulse `start` with A=0x9, B=0x9 two cycles later → single `done` at t0+4 with DIFF=0x000000FF, BO=0. No second `done` follows.
- Back-to-back: first op A=10, B=4; `start` asserted in its `done` cycle with A=3, B=5 → first result DIFF=6, BO=0. Exactly 4 cycles later, DIFF=0xFFFFFFFE, BO=1.
- Reset mid-operation: accept A=0x55, B=0x11, drop `rst_n` asynchronously after 2 cycles → `busy`/`done`/`DIFF`/`BO` all 0 immediately. They remain 0 with no `done` for 10 cycles after release, until the next `start`.

Source files
------------

// File: rtl/dw01_sub_seq.sv
// Multi-cycle unsigned subtractor: DIFF = A - B - BI, one chunk-bit slice per cycle,
// LSB slice first, with a start/busy/done handshake and registered results.
module dw01_sub_seq #(
  parameter int width = 32,
  parameter int chunk = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             BI,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] DIFF,
  output logic             BO
);

  localparam int N  = width / chunk;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [width-1:0] r_a;
  logic [width-1:0] r_b;
  logic             r_borrow;
  logic             r_busy;

  logic [chunk:0]   w_part;
  logic             w_last;
  logic [width-1:0] w_acc_next;

  // Operand registers shift right each cycle, so the active slice is always the low chunk.
  assign w_part = {1'b0, r_a[chunk-1:0]} - {1'b0, r_b[chunk-1:0]} - {{chunk{1'b0}}, r_borrow};
  assign w_last = (r_cnt == CW'(N - 1));
  assign busy   = r_busy;

  // Accumulator slices; w_acc_next folds in the slice being computed this cycle so the
  // completing edge can publish the full result including the final slice.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      logic [chunk-1:0] r_slice;
      logic             w_hit;

      assign w_hit = (r_state == S_RUN) && (r_cnt == CW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_slice <= '0;
        end else if (w_hit) begin
          r_slice <= w_part[chunk-1:0];
        end
      end

      assign w_acc_next[gi*chunk +: chunk] = w_hit ? w_part[chunk-1:0] : r_slice;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      done     <= 1'b0;
      DIFF     <= '0;
      BO       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= BI;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> chunk;
          r_b      <= r_b >> chunk;
          r_borrow <= w_part[chunk];
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            DIFF    <= w_acc_next;
            BO      <= w_part[chunk];
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dw01_sub_seq.sv
// Self-checking bench for dw01_sub_seq: directed test-plan cases plus random operations
// checked against a plain-arithmetic reference of A - B - BI.
module tb_dw01_sub_seq;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic         busy;
  logic         done;
  logic [W-1:0] DIFF;
  logic         BO;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc_total = 0;
  int busy_total = 0;
  int done_total = 0;
  int t0;
  int b0;

  dw01_sub_seq #(.width(W), .chunk(C)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .BI   (BI),
    .busy (busy),
    .done (done),
    .DIFF (DIFF),
    .BO   (BO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge counters; they see pre-edge values of busy/done.
  always @(posedge clk) begin
    cyc_total  <= cyc_total + 1;
    busy_total <= busy_total + (busy ? 1 : 0);
    done_total <= done_total + (done ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge: present an operation, let the next edge accept it.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    A = a; B = b; BI = bi; start = 1'b1;
    t0 = cyc_total + 1;
    b0 = busy_total;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; BI = 1'($urandom);
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc_total - t0), 64'(N));
    chk({tag, "_busy_cycles"}, 64'(busy_total - b0), 64'(N));
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bi);
    logic [W-1:0] exp_d;
    logic         exp_bo;
    exp_d  = a - b - W'(bi);
    exp_bo = ({1'b0, a} < ({1'b0, b} + 33'(bi)));
    $display("op %s: A=%h B=%h BI=%0d -> DIFF=%h BO=%0d (ref %h/%0d)",
             tag, a, b, bi, DIFF, BO, exp_d, exp_bo);
    chk({tag, "_diff"}, 64'(DIFF), 64'(exp_d));
    chk({tag, "_bo"}, 64'(BO), 64'(exp_bo));
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi);
    launch(a, b, bi);
    wait_done(tag);
    chk_result(tag, a, b, bi);
  endtask

  logic [W-1:0] ta  [6] = '{32'h00000005, 32'h00000000, 32'h80000000,
                            32'h12345678, 32'h12345678, 32'hFFFFFFFF};
  logic [W-1:0] tb_ [6] = '{32'h00000003, 32'h00000001, 32'h00000001,
                            32'h12345678, 32'h12345678, 32'hFFFFFFFF};
  logic         tbi [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int d0;
    logic [W-1:0] ra, rb;
    logic         rbi;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; BI = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_diff", 64'(DIFF), 64'd0);
    chk("reset_bo", 64'(BO), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan vectors
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("dir%0d", i), ta[i], tb_[i], tbi[i]);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
    end

    // Start while busy must be ignored
    launch(32'h100, 32'h1, 1'b0);
    @(negedge clk);
    A = 32'h9; B = 32'h9; BI = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ign");
    chk_result("busy_ign", 32'h100, 32'h1, 1'b0);
    @(negedge clk);
    d0 = done_total;
    repeat (8) @(negedge clk);
    chk("busy_ign_no_2nd_done", 64'(done_total - d0), 64'd0);
    chk("diff_hold_idle", 64'(DIFF), 64'h000000FF);

    // Back-to-back: second start issued in the done cycle of the first
    do_op("b2b_1", 32'd10, 32'd4, 1'b0);
    do_op("b2b_2", 32'd3, 32'd5, 1'b0);
    @(negedge clk);

    // Random operations, sometimes back-to-back, sometimes with idle gaps
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      rbi = 1'($urandom);
      do_op($sformatf("rnd%0d", i), ra, rb, rbi);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset mid-operation
    launch(32'h55, 32'h11, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_diff", 64'(DIFF), 64'd0);
    chk("rst_mid_bo", 64'(BO), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_total;
    repeat (10) @(negedge clk);
    chk("rst_after_no_done", 64'(done_total - d0), 64'd0);
    chk("rst_after_busy", 64'(busy), 64'd0);
    chk("rst_after_diff", 64'(DIFF), 64'd0);
    chk("rst_after_bo", 64'(BO), 64'd0);

    do_op("post_rst", 32'h55, 32'h11, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
